out_fifo_axis: RTL and testbench

- Output data FIFO sitting directly downstream of the DTPU control unit and MXU.
- Buffers MXU result words written under control-unit command (outfifo_write / outfifo_is_full handshake).
- Drains them to the PS-side DMA as an AXI4-Stream master, inserting TLAST at packet boundaries.
- Reports occupancy, overflow and packet completion back to the control unit and CSR.

---
 rtl/out_fifo_axis_pkg.sv | 20 ++
 rtl/out_fifo_axis_sdp_ram.sv | 20 ++
 rtl/out_fifo_axis.sv | 112 +++++++++++
 tb/tb_out_fifo_axis.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_fifo_axis_pkg.sv
// Shared constants and types for the output FIFO / AXI4-Stream drain block.
package out_fifo_axis_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_W_DEF     = 4;
  localparam int PACKET_LEN_DEF = 16;
  localparam int BEAT_W         = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH_DEF/8-1:0] TKEEP_ALL = '1;

  // Beat-counter value at which the next accepted word closes a packet.
  function automatic logic [BEAT_W-1:0] beat_limit(input int packet_len);
    return BEAT_W'(packet_len - 1);
  endfunction
endpackage

// File: rtl/out_fifo_axis_sdp_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module out_fifo_axis_sdp_ram #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 65
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/out_fifo_axis.sv
// Output FIFO buffering MXU results and draining them as an AXI4-Stream master
// with automatic or forced TLAST at packet boundaries.
module out_fifo_axis
  import out_fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PACKET_LEN = PACKET_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_last,
  output logic                    full,
  output logic                    empty,
  output logic [ADDR_W:0]         count,
  output logic                    overflow,
  output logic                    pkt_done,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
);
  logic [ADDR_W:0]     wr_ptr, rd_ptr, count_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                overflow_q, pkt_done_q;
  logic                push, pop, last_in;
  logic [DATA_WIDTH:0] rd_word;
  state_t              state, state_nxt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign push    = wr_en & ~full;
  assign pop     = ~empty & m_axis_tready;
  assign last_in = wr_last | (beat_cnt == beat_limit(PACKET_LEN));

  out_fifo_axis_sdp_ram #(
    .ADDR_W(ADDR_W),
    .WIDTH (DATA_WIDTH + 1)
  ) u_ram (
    .clk  (clk),
    .we   (push & ~clear),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata({last_in, wr_data}),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rd_word)
  );

  // First-word-fall-through read side straight from the RAM's async port.
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
  assign m_axis_tlast  = rd_word[DATA_WIDTH];
  assign m_axis_tkeep  = '1;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign pkt_done      = pkt_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      beat_cnt   <= '0;
      overflow_q <= 1'b0;
      pkt_done_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      beat_cnt   <= '0;
      overflow_q <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        beat_cnt <= last_in ? '0 : beat_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow_q <= 1'b1;
      pkt_done_q <= pop & m_axis_tlast;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  // A TLAST pop leaves DRAIN for STREAM whenever words of the next packet are
  // already queued or arriving this cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = last_in ? DRAIN : STREAM;
      STREAM:  if (push && last_in) state_nxt = DRAIN;
      DRAIN:   if (pop && m_axis_tlast)
                 state_nxt = (push || count_q > 1) ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_out_fifo_axis.sv
// Randomized self-checking bench for out_fifo_axis against a queue-based model.
module tb_out_fifo_axis;
  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PL    = 4;

  logic          clk = 1'b0;
  logic          reset, clear, wr_en, wr_last, m_axis_tready;
  logic [DW-1:0] wr_data;
  logic          full, empty, overflow, pkt_done;
  logic [AW:0]   count;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic [DW/8-1:0] m_axis_tkeep;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW:0] mq[$];
  int          m_beat = 0;
  bit          m_ovf  = 0;
  bit          m_pkt  = 0;

  out_fifo_axis #(.DATA_WIDTH(DW), .ADDR_W(AW), .PACKET_LEN(PL)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .wr_last(wr_last), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .pkt_done(pkt_done), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Model advances by one clock edge using the currently driven inputs.
  task automatic tick();
    bit push, pop, lastin;
    int sz;
    sz = mq.size();
    if (clear) begin
      mq.delete();
      m_beat = 0; m_ovf = 0; m_pkt = 0;
    end else begin
      pop  = (sz != 0) && m_axis_tready;
      push = wr_en && (sz < DEPTH);
      m_pkt = 0;
      if (pop) m_pkt = mq[0][DW];
      if (wr_en && sz == DEPTH) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (push) begin
        lastin = wr_last || (m_beat == PL - 1);
        mq.push_back({lastin, wr_data});
        m_beat = lastin ? 0 : m_beat + 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1; wr_en = 0; wr_last = 0; m_axis_tready = 0;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    n_checks++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (overflow !== 1'b0 || pkt_done !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b%b exp=00", overflow, pkt_done); end
    n_checks++; if (m_axis_tkeep !== 8'hFF) begin n_err++; $display("FAIL tkeep got=%h exp=ff", m_axis_tkeep); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals[3] = '{64'h11, 64'h22, 64'h33};
    logic [DW-1:0] got[$];
    do_clear();
    m_axis_tready = 1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = vals[i];
      if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
      tick();
      if (i == 0) begin
        n_checks++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL basic_latency tvalid got=%b exp=1", m_axis_tvalid); end
      end
    end
    wr_en = 0;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
      tick();
    end
    n_checks++; if (got.size() !== 3) begin n_err++; $display("FAIL basic_nbeats got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== vals[i]) begin n_err++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got[i], vals[i]); end
    end
    n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin n_err++; $display("FAIL basic_end empty=%b count=%0d exp 1/0", empty, count); end
  endtask

  task automatic test_full_overflow();
    logic [DW-1:0] sent[$];
    int n;
    do_clear();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; wr_data = {$urandom, $urandom}; sent.push_back(wr_data);
      tick();
      if (i == 15) begin
        n_checks++; if (full !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL full_after16 full=%b count=%0d exp 1/16", full, count); end
        n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    wr_en = 0;
    n_checks++; if (overflow !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL overflow ovf=%b count=%0d exp 1/16", overflow, count); end
    m_axis_tready = 1; n = 0;
    for (int c = 0; c < 24; c++) begin
      if (m_axis_tvalid) begin
        if (n < 16) begin
          n_checks++; if (m_axis_tdata !== sent[n]) begin n_err++; $display("FAIL full_data[%0d] got=%h exp=%h", n, m_axis_tdata, sent[n]); end
        end
        n++;
      end
      tick();
    end
    n_checks++; if (n !== 16) begin n_err++; $display("FAIL full_nbeats got=%0d exp=16", n); end
    n_checks++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_auto_tlast();
    int beat, pulses, nw;
    int lastbeats[$];
    do_clear();
    m_axis_tready = 1; beat = 0; pulses = 0; nw = 0;
    for (int c = 0; c < 30; c++) begin
      wr_en = (nw < 8); wr_data = {$urandom, $urandom};
      if (wr_en) nw++;
      if (m_axis_tvalid && m_axis_tready) begin
        beat++;
        if (m_axis_tlast) lastbeats.push_back(beat);
      end
      tick();
      if (pkt_done) pulses++;
    end
    wr_en = 0;
    n_checks++; if (lastbeats.size() !== 2) begin n_err++; $display("FAIL auto_tlast_n got=%0d exp=2", lastbeats.size()); end
    else begin
      n_checks++; if (lastbeats[0] !== 4 || lastbeats[1] !== 8) begin n_err++; $display("FAIL auto_tlast_pos got=%0d,%0d exp=4,8", lastbeats[0], lastbeats[1]); end
    end
    n_checks++; if (pulses !== 2) begin n_err++; $display("FAIL pkt_done_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_forced_tlast();
    logic [5:0] pat, exp_pat;
    int n;
    exp_pat = 6'b100010;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_last = (i == 1); wr_data = DW'(i + 100);
      tick();
    end
    wr_en = 0; wr_last = 0; m_axis_tready = 1; pat = '0; n = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_axis_tvalid && n < 6) begin pat[n] = m_axis_tlast; n++; end
      tick();
    end
    n_checks++; if (pat !== exp_pat || n !== 6) begin n_err++; $display("FAIL forced_tlast got=%b n=%0d exp=%b n=6", pat, n, exp_pat); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = {$urandom, $urandom}; tick();
    end
    m_axis_tready = 1;
    for (int c = 0; c < 20; c++) begin
      wr_en = 1; wr_data = {$urandom, $urandom};
      n_checks++; if (!m_axis_tvalid || m_axis_tdata !== mq[0][DW-1:0] || m_axis_tlast !== mq[0][DW]) begin
        n_err++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", c, m_axis_tvalid, m_axis_tdata, mq[0][DW-1:0]); end
      tick();
      n_checks++; if (count !== 5'(c == 0 ? 15 : 15) || count !== 5'(mq.size())) begin
        n_err++; $display("FAIL b2b_count[%0d] got=%0d exp=15", c, count); end
    end
    wr_en = 0;
  endtask

  task automatic test_random();
    int errs0;
    errs0 = n_err;
    do_clear();
    for (int c = 0; c < 600; c++) begin
      wr_en = ($urandom_range(0, 99) < 60); wr_last = ($urandom_range(0, 9) == 0);
      wr_data = {$urandom, $urandom}; m_axis_tready = ($urandom_range(0, 99) < 50);
      clear = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (m_axis_tvalid !== (mq.size() != 0) || count !== 5'(mq.size()) ||
          full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
          overflow !== m_ovf || pkt_done !== m_pkt ||
          (mq.size() != 0 && (m_axis_tdata !== mq[0][DW-1:0] || m_axis_tlast !== mq[0][DW]))) begin
        n_err++;
        if (n_err - errs0 < 5)
          $display("FAIL rand[%0d] got v=%b c=%0d f=%b e=%b o=%b p=%b l=%b d=%h exp c=%0d o=%b p=%b",
                   c, m_axis_tvalid, count, full, empty, overflow, pkt_done, m_axis_tlast, m_axis_tdata,
                   mq.size(), m_ovf, m_pkt);
      end
    end
    clear = 0; wr_en = 0; wr_last = 0;
  endtask

  task automatic test_clear_mid();
    do_clear();
    for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = {$urandom, $urandom}; tick(); end
    for (int i = 0; i < 4; i++) begin wr_en = 1; m_axis_tready = i[0]; tick(); end
    clear = 1; wr_en = 1; m_axis_tready = 1;
    tick();
    clear = 0; wr_en = 0;
    n_checks++; if (empty !== 1'b1 || m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
      n_err++; $display("FAIL clear_mid empty=%b tvalid=%b count=%0d exp 1/0/0", empty, m_axis_tvalid, count); end
    n_checks++; if (overflow !== 1'b0 || pkt_done !== 1'b0) begin n_err++; $display("FAIL clear_flags got=%b%b exp=00", overflow, pkt_done); end
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 17; i++) begin wr_en = 1; wr_data = {$urandom, $urandom}; tick(); end
    wr_en = 0;
    #2 reset = 0;
    #1;
    mq.delete(); m_beat = 0; m_ovf = 0; m_pkt = 0;
    n_checks++; if (m_axis_tvalid !== 1'b0 || empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
      n_err++; $display("FAIL async_reset tvalid=%b empty=%b count=%0d full=%b exp 0/1/0/0", m_axis_tvalid, empty, count, full); end
    n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL async_reset_ovf got=%b exp=0", overflow); end
    @(posedge clk); #3 reset = 1;
    @(posedge clk); #1;
    wr_en = 1; wr_data = 64'hABCD; tick(); wr_en = 0;
    n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hABCD || count !== 5'd1) begin
      n_err++; $display("FAIL post_reset_write tvalid=%b data=%h count=%0d exp 1/abcd/1", m_axis_tvalid, m_axis_tdata, count); end
  endtask

  initial begin
    reset = 0; clear = 0; wr_en = 0; wr_last = 0; wr_data = '0; m_axis_tready = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1;
    @(posedge clk); #1;
    test_basic();
    test_full_overflow();
    test_auto_tlast();
    test_forced_tlast();
    test_back_to_back();
    test_clear_mid();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
